// File: rtl/nf5_boot_loader.sv
// nf5_boot_loader: loads a length-prefixed little-endian program image into the memory write
// port and holds the core in reset until done. Define NF5_BOOT_CSUM_EN for a trailing checksum.
module nf5_boot_loader #(
    parameter int unsigned       ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_busy,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);

    // Largest word count that fits between BASE_ADDR and the top of memory.
    localparam logic [32:0] MAX_WORDS = (33'(1) << ADDR_W) - 33'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef NF5_BOOT_CSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [23:0] byte_buf;
    logic [31:0] remaining;
`ifdef NF5_BOOT_CSUM_EN
    logic [31:0] csum;
`endif

    logic        accept_c;
    logic        last_byte_c;
    logic [31:0] full_word_c;

    assign accept_c    = s_valid && s_ready;
    assign last_byte_c = accept_c && (byte_idx == 2'd3);
    assign full_word_c = {s_data, byte_buf};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_idx   <= 2'd0;
            byte_buf   <= '0;
            remaining  <= '0;
            s_ready    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef NF5_BOOT_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            // Bytes shift in from the top so byte_buf holds {b2,b1,b0} before the 4th byte.
            if (accept_c) begin
                byte_idx <= byte_idx + 2'd1;
                byte_buf <= {s_data, byte_buf[23:8]};
            end

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_HDR;
                        s_ready    <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        core_rst_n <= 1'b0;
                        byte_idx   <= 2'd0;
                        mem_addr   <= BASE_ADDR;
`ifdef NF5_BOOT_CSUM_EN
                        csum       <= '0;
`endif
                    end
                end

                S_HDR: begin
                    if (last_byte_c) begin
                        remaining <= full_word_c;
                        if ({1'b0, full_word_c} > MAX_WORDS) begin
                            state   <= S_ERR;
                            s_ready <= 1'b0;
                            err     <= 1'b1;
                        end else if (full_word_c == 32'd0) begin
`ifdef NF5_BOOT_CSUM_EN
                            state      <= S_CSUM;
`else
                            state      <= S_DONE;
                            s_ready    <= 1'b0;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (last_byte_c) begin
                        state     <= S_WRITE;
                        s_ready   <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_wdata <= full_word_c;
`ifdef NF5_BOOT_CSUM_EN
                        csum      <= csum + full_word_c;
`endif
                    end
                end

                // Address and data hold while the memory stalls.
                S_WRITE: begin
                    if (!mem_busy) begin
                        mem_we    <= 1'b0;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        remaining <= remaining - 32'd1;
                        if (remaining == 32'd1) begin
`ifdef NF5_BOOT_CSUM_EN
                            state      <= S_CSUM;
                            s_ready    <= 1'b1;
`else
                            state      <= S_DONE;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
`endif
                        end else begin
                            state   <= S_DATA;
                            s_ready <= 1'b1;
                        end
                    end
                end

`ifdef NF5_BOOT_CSUM_EN
                S_CSUM: begin
                    if (last_byte_c) begin
                        s_ready <= 1'b0;
                        if (full_word_c == csum) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state   <= S_IDLE;
                    s_ready <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nf5_boot_loader.sv
// Directed bench for nf5_boot_loader: normal load, memory stall, oversize header,
// mid-load reset, gappy byte stream and (when NF5_BOOT_CSUM_EN is set) checksum handling.
module tb_nf5_boot_loader;

    localparam int unsigned ADDR_W = 12;
`ifdef NF5_BOOT_CSUM_EN
    localparam int CS_BYTES = 4;
`else
    localparam int CS_BYTES = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_busy = 1'b0;
    logic              core_rst_n;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    int                acc_cnt = 0;
    int                ready_in_write = 0;

    nf5_boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR('0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_busy(mem_busy),
        .core_rst_n(core_rst_n), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so the negedge sees a stable cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we && !mem_busy) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end
            if (s_valid && s_ready) acc_cnt++;
            if (mem_we && s_ready) ready_in_write++;
        end
    end

    function automatic logic [31:0] wdata_at(input int i);
        return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [ADDR_W-1:0] waddr_at(input int i);
        return (i < wr_addr_q.size()) ? wr_addr_q[i] : 'x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        acc_cnt = 0;
        ready_in_write = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data = b;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = s_ready;
            tick();
            n++;
        end
        s_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_byte_timeout byte %h not accepted in %0d cycles", b, n);
        end
        if (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic send_csum(input logic [31:0] w, input bit gap);
`ifdef NF5_BOOT_CSUM_EN
        send_word(w, gap);
`else
        if (gap && w === 32'hffffffff) tick();
`endif
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done || err) && n < 100);
        tick();
        checks++;
        if (!(done || err)) begin
            errors++;
            $display("FAIL wait_end_timeout done=%b err=%b after %0d cycles", done, err, n);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({s_ready, mem_we, mem_addr, mem_wdata, core_rst_n, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b we=%b addr=%h wd=%h crst=%b done=%b err=%b exp all 0",
                     s_ready, mem_we, mem_addr, mem_wdata, core_rst_n, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        clear_log();
        s_valid = 1'b1;
        s_data = 8'h5A;
        repeat (3) tick();
        s_valid = 1'b0;
        checks++;
        if (acc_cnt !== 0) begin
            errors++;
            $display("FAIL idle_no_accept got %0d bytes exp 0", acc_cnt);
        end
    endtask

    task automatic test_basic();
        clear_log();
        pulse_start();
        checks++;
        if (s_ready !== 1'b1 || core_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL start_hdr got rdy=%b crst=%b exp 1 0", s_ready, core_rst_n);
        end
        send_word(32'd2, 1'b0);
        send_word(32'h13, 1'b0);
        checks++;
        if ({mem_we, s_ready, mem_addr, mem_wdata} !== {1'b1, 1'b0, 12'h000, 32'h13}) begin
            errors++;
            $display("FAIL first_write_latency got we=%b rdy=%b addr=%h wd=%h exp 1 0 000 00000013",
                     mem_we, s_ready, mem_addr, mem_wdata);
        end
        send_word(32'h6F, 1'b0);
        send_csum(32'h82, 1'b0);
        wait_end();
        checks++;
        if ({done, core_rst_n, err, s_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL basic_done got done=%b crst=%b err=%b rdy=%b exp 1 1 0 0",
                     done, core_rst_n, err, s_ready);
        end
        checks++;
        if (wr_data_q.size() != 2 || wdata_at(0) !== 32'h13 || waddr_at(0) !== 12'h000
            || wdata_at(1) !== 32'h6F || waddr_at(1) !== 12'h001) begin
            errors++;
            $display("FAIL basic_writes got n=%0d %h@%h %h@%h exp 2 00000013@000 0000006f@001",
                     wr_data_q.size(), wdata_at(0), waddr_at(0), wdata_at(1), waddr_at(1));
        end
        checks++;
        if (ready_in_write !== 0 || acc_cnt !== 12 + CS_BYTES) begin
            errors++;
            $display("FAIL basic_handshake got ready_in_write=%0d accepted=%0d exp 0 %0d",
                     ready_in_write, acc_cnt, 12 + CS_BYTES);
        end
    endtask

    task automatic test_busy();
        clear_log();
        mem_busy = 1'b1;
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'h13, 1'b0);
        s_valid = 1'b1;
        s_data = 8'h6F;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, s_ready, mem_addr, mem_wdata} !== {1'b1, 1'b0, 12'h000, 32'h13}) begin
                errors++;
                $display("FAIL busy_hold cycle %0d got we=%b rdy=%b addr=%h wd=%h exp 1 0 000 00000013",
                         c, mem_we, s_ready, mem_addr, mem_wdata);
            end
            tick();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_4th_cycle got we=%b rdy=%b exp 1 0", mem_we, s_ready);
        end
        tick();
        s_valid = 1'b0;
        checks++;
        if (acc_cnt !== 8 || wr_data_q.size() != 1) begin
            errors++;
            $display("FAIL busy_no_accept got accepted=%0d writes=%0d exp 8 1", acc_cnt, wr_data_q.size());
        end
        send_word(32'h6F, 1'b0);
        send_csum(32'h82, 1'b0);
        wait_end();
        checks++;
        if (done !== 1'b1 || wr_data_q.size() != 2 || wdata_at(0) !== 32'h13 || waddr_at(0) !== 12'h000
            || wdata_at(1) !== 32'h6F || waddr_at(1) !== 12'h001) begin
            errors++;
            $display("FAIL busy_writes got done=%b n=%0d %h@%h %h@%h exp 1 2 00000013@000 0000006f@001",
                     done, wr_data_q.size(), wdata_at(0), waddr_at(0), wdata_at(1), waddr_at(1));
        end
    endtask

    task automatic test_err();
        clear_log();
        pulse_start();
        checks++;
        if (done !== 1'b0 || core_rst_n !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear got done=%b crst=%b rdy=%b exp 0 0 1", done, core_rst_n, s_ready);
        end
        send_word(32'h0000_1001, 1'b0);
        repeat (3) tick();
        checks++;
        if ({err, done, core_rst_n, s_ready, mem_we} !== 5'b10000 || wr_data_q.size() != 0) begin
            errors++;
            $display("FAIL oversize_err got err=%b done=%b crst=%b rdy=%b we=%b writes=%0d exp 1 0 0 0 0 0",
                     err, done, core_rst_n, s_ready, mem_we, wr_data_q.size());
        end
        pulse_start();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got err=%b exp 0", err);
        end
        send_word(32'd0, 1'b0);
        send_csum(32'd0, 1'b0);
        wait_end();
        checks++;
        if ({done, err, core_rst_n} !== 3'b101 || wr_data_q.size() != 0) begin
            errors++;
            $display("FAIL zero_len got done=%b err=%b crst=%b writes=%0d exp 1 0 1 0",
                     done, err, core_rst_n, wr_data_q.size());
        end
    endtask

    task automatic test_async_reset();
        clear_log();
        pulse_start();
        send_word(32'd1, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h33, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, mem_we, mem_addr, mem_wdata, core_rst_n, done, err} !== '0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b we=%b addr=%h wd=%h crst=%b done=%b err=%b exp all 0",
                     s_ready, mem_we, mem_addr, mem_wdata, core_rst_n, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        clear_log();
        pulse_start();
        send_word(32'd1, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        send_csum(32'h1122_3344, 1'b0);
        wait_end();
        checks++;
        if (done !== 1'b1 || wr_data_q.size() != 1 || wdata_at(0) !== 32'h1122_3344 || waddr_at(0) !== 12'h000) begin
            errors++;
            $display("FAIL reload_after_reset got done=%b n=%0d %h@%h exp 1 1 11223344@000",
                     done, wr_data_q.size(), wdata_at(0), waddr_at(0));
        end
    endtask

    task automatic test_toggle();
        clear_log();
        pulse_start();
        send_word(32'd1, 1'b1);
        pulse_start();
        send_word(32'hAABB_CCDD, 1'b1);
        send_csum(32'hAABB_CCDD, 1'b1);
        wait_end();
        checks++;
        if (acc_cnt !== 8 + CS_BYTES || wr_data_q.size() != 1) begin
            errors++;
            $display("FAIL toggle_count got accepted=%0d writes=%0d exp %0d 1",
                     acc_cnt, wr_data_q.size(), 8 + CS_BYTES);
        end
        checks++;
        if (done !== 1'b1 || wdata_at(0) !== 32'hAABB_CCDD || waddr_at(0) !== 12'h000) begin
            errors++;
            $display("FAIL toggle_data got done=%b %h@%h exp 1 aabbccdd@000", done, wdata_at(0), waddr_at(0));
        end
    endtask

`ifdef NF5_BOOT_CSUM_EN
    task automatic test_csum();
        clear_log();
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd3, 1'b0);
        wait_end();
        checks++;
        if ({done, err, core_rst_n} !== 3'b101) begin
            errors++;
            $display("FAIL csum_match got done=%b err=%b crst=%b exp 1 0 1", done, err, core_rst_n);
        end
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd4, 1'b0);
        wait_end();
        checks++;
        if ({done, err, core_rst_n} !== 3'b010 || wr_data_q.size() != 4) begin
            errors++;
            $display("FAIL csum_mismatch got done=%b err=%b crst=%b writes=%0d exp 0 1 0 4",
                     done, err, core_rst_n, wr_data_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_busy();
        test_err();
        test_async_reset();
        test_toggle();
`ifdef NF5_BOOT_CSUM_EN
        test_csum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
